// File: rtl/water_pkg.sv
// water_pkg
//   Shared constants for the water-level blocks (level_alarm_ctrl, display,
//   led_matrix): alarm state codes, default thresholds and timing constants,
//   plus the threshold-only level classifier.
//   No ports.
package water_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_NORMAL = 3'd1,
      ST_LOW    = 3'd2,
      ST_HIGH   = 3'd3,
      ST_OVER   = 3'd4,
      ST_FAULT  = 3'd5
   } state_e;

   localparam int unsigned DEF_TICK_DIV = 50000;
   localparam int unsigned DEF_LOW_TH   = 20;
   localparam int unsigned DEF_HIGH_TH  = 80;
   localparam int unsigned DEF_OVER_TH  = 95;
   localparam int unsigned DEF_HYST     = 3;
   localparam int unsigned DEF_DEB_MS   = 20;

   localparam logic [9:0] MS_LAST       = 10'd999;
   localparam logic [9:0] BEEP_LOW_MS   = 10'd100;
   localparam logic [9:0] BEEP_HIGH_MS  = 10'd500;
   localparam logic [9:0] ANIME_STEP1   = 10'd250;
   localparam logic [9:0] ANIME_STEP2   = 10'd500;
   localparam logic [9:0] ANIME_STEP3   = 10'd750;

   // Plain threshold classification, no hysteresis.
   function automatic state_e classify_raw(input logic [6:0] level,
                                           input logic [6:0] low_th,
                                           input logic [6:0] high_th,
                                           input logic [6:0] over_th);
      if (level < low_th)       return ST_LOW;
      else if (level < high_th) return ST_NORMAL;
      else if (level < over_th) return ST_HIGH;
      else                      return ST_OVER;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Debounces a raw push button. The button must stay high for DEB_MS
//   consecutive ticks; then a single one-cycle press pulse is produced.
//   The button must drop low before another press can be produced.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   tick    - one-cycle 1 ms strobe
//   btn_raw - raw, asynchronous button level
//   press   - one-cycle debounced press pulse
module btn_debounce
   import water_pkg::*;
#(
   parameter int unsigned DEB_MS = DEF_DEB_MS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned CW = (DEB_MS > 1) ? $clog2(DEB_MS + 1) : 1;

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          press_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         // two-flop synchroniser, the button is asynchronous to clk
         sync_q  <= {sync_q[0], btn_raw};
         press_q <= 1'b0;
         if (!sync_q[1]) begin
            cnt_q <= '0;
         end else if (tick && (cnt_q != CW'(DEB_MS))) begin
            // saturates at DEB_MS so a held button fires only once
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DEB_MS - 1)) press_q <= 1'b1;
         end
      end
   end

   assign press = press_q;

endmodule

// File: rtl/level_alarm_ctrl.sv
// level_alarm_ctrl
//   Water-level alarm controller. Converts BCD samples to a binary level,
//   classifies them into alarm states with hysteresis, and drives the beeper
//   pattern, mute flag and LED-matrix animation phase.
// Ports:
//   clk          - system clock
//   rst          - synchronous active-high reset
//   number[7:0]  - BCD sample, tens in [7:4], ones in [3:0]
//   number_valid - one-cycle strobe marking a new sample
//   btn0         - raw acknowledge/mute button
//   state[2:0]   - current alarm state code (water_pkg::state_e)
//   beep_en      - beeper enable
//   anime_state  - animation phase, advances every 250 ms in alarm states
//   muted        - alarm acknowledged
module level_alarm_ctrl
   import water_pkg::*;
#(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV,
   parameter int unsigned LOW_TH   = DEF_LOW_TH,
   parameter int unsigned HIGH_TH  = DEF_HIGH_TH,
   parameter int unsigned OVER_TH  = DEF_OVER_TH,
   parameter int unsigned HYST     = DEF_HYST,
   parameter int unsigned DEB_MS   = DEF_DEB_MS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] number,
   input  logic       number_valid,
   input  logic       btn0,
   output logic [2:0] state,
   output logic       beep_en,
   output logic [1:0] anime_state,
   output logic       muted
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [6:0] LOW_LV   = 7'(LOW_TH);
   localparam logic [6:0] HIGH_LV  = 7'(HIGH_TH);
   localparam logic [6:0] OVER_LV  = 7'(OVER_TH);
   localparam logic [6:0] LOW_REC  = 7'(LOW_TH + HYST);
   localparam logic [6:0] HIGH_DN  = 7'(HIGH_TH - HYST);
   localparam logic [6:0] OVER_DN  = 7'(OVER_TH - HYST);

   state_e        state_q, state_d, raw_class;
   logic [TW-1:0] tick_cnt_q;
   logic          tick;
   logic [6:0]    level_q;
   logic          sample_q;
   logic          bcd_err_q;
   logic [9:0]    ms_q;
   logic          muted_q;
   logic          press;
   logic          state_chg;
   logic          alarm_st;
   logic          pattern;

   // ---------------------------------------------------------------- timers
   assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) tick_cnt_q <= '0;
      else     tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
   end

   // --------------------------------------------------------- sample capture
   // The level is registered on the strobe edge; classification happens on
   // the following edge from the registered copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q   <= '0;
         sample_q  <= 1'b0;
         bcd_err_q <= 1'b0;
      end else begin
         sample_q <= number_valid;
         if (number_valid) begin
            level_q   <= {3'b000, number[7:4]} * 7'd10 + {3'b000, number[3:0]};
            bcd_err_q <= (number[7:4] > 4'd9) || (number[3:0] > 4'd9);
         end
      end
   end

   // ------------------------------------------------------- FSM: state reg
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ------------------------------------------------------ FSM: next state
   always_comb begin
      raw_class = classify_raw(level_q, LOW_LV, HIGH_LV, OVER_LV);
      state_d   = state_q;
      if (sample_q) begin
         if (bcd_err_q) begin
            state_d = ST_FAULT;
         end else begin
            unique case (state_q)
               ST_LOW: begin
                  if ((raw_class == ST_NORMAL) && (level_q < LOW_REC))
                     state_d = ST_LOW;
                  else
                     state_d = raw_class;
               end
               ST_HIGH: begin
                  if ((raw_class == ST_HIGH) || (raw_class == ST_OVER))
                     state_d = raw_class;
                  else if (level_q >= HIGH_DN)
                     state_d = ST_HIGH;
                  else
                     state_d = raw_class;
               end
               // leaving OVER still passes through the HIGH hysteresis band
               ST_OVER: begin
                  if (level_q >= OVER_DN)      state_d = ST_OVER;
                  else if (level_q >= HIGH_DN) state_d = ST_HIGH;
                  else                         state_d = raw_class;
               end
               default: state_d = raw_class;
            endcase
         end
      end
   end

   assign state_chg = (state_d != state_q);
   assign alarm_st  = (state_q == ST_LOW) || (state_q == ST_HIGH) ||
                      (state_q == ST_OVER);

   // ------------------------------------------------- ms counter and mute
   always_ff @(posedge clk) begin
      if (rst) begin
         ms_q    <= '0;
         muted_q <= 1'b0;
      end else begin
         if (state_chg)  ms_q <= '0;
         else if (tick)  ms_q <= (ms_q == MS_LAST) ? '0 : ms_q + 10'd1;

         // a state change clears mute even if a press lands on the same edge
         if (state_chg)                  muted_q <= 1'b0;
         else if (press && alarm_st)     muted_q <= 1'b1;
      end
   end

   btn_debounce #(
      .DEB_MS (DEB_MS)
   ) u_btn_debounce (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .btn_raw (btn0),
      .press   (press)
   );

   // ---------------------------------------------------------- FSM: outputs
   always_comb begin
      pattern     = 1'b0;
      anime_state = 2'd0;
      unique case (state_q)
         ST_LOW:  pattern = (ms_q < BEEP_LOW_MS);
         ST_HIGH: pattern = (ms_q < BEEP_HIGH_MS);
         ST_OVER: pattern = 1'b1;
         default: pattern = 1'b0;
      endcase
      beep_en = (state_q == ST_OVER) ? pattern : (pattern & ~muted_q);
      // phase is ms/250, which steps at ms = 0, 250, 500, 750
      if (alarm_st) begin
         if (ms_q >= ANIME_STEP3)      anime_state = 2'd3;
         else if (ms_q >= ANIME_STEP2) anime_state = 2'd2;
         else if (ms_q >= ANIME_STEP1) anime_state = 2'd1;
         else                          anime_state = 2'd0;
      end
      state = state_q;
      muted = muted_q;
   end

endmodule

// File: doc/level_alarm_ctrl.md
LEVEL_ALARM_CTRL -- requirements
Module: level_alarm_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per 1 ms tick.
REQ-002 SHALL have parameter LOW_TH, default 20, meaning low-level threshold in percent.
REQ-003 SHALL have parameter HIGH_TH, default 80, meaning high-level threshold in percent.
REQ-004 SHALL have parameter OVER_TH, default 95, meaning overflow threshold in percent.
REQ-005 SHALL have parameter HYST, default 3, meaning hysteresis band in percent.
REQ-006 SHALL have parameter DEB_MS, default 20, meaning btn0 debounce time in ticks.
REQ-007 SHALL have port clk, input, 1, system clock; the block uses one clock, clk.
REQ-008 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-009 SHALL have port number, input, 8, two BCD digits (tens in [7:4], ones in [3:0]).
REQ-010 SHALL have port number_valid, input, 1, one-cycle strobe marking a new sample.
REQ-011 SHALL have port btn0, input, 1, raw acknowledge/mute button.
REQ-012 SHALL have port state, output, 3, current alarm state code.
REQ-013 SHALL have port beep_en, output, 1, beeper enable pattern.
REQ-014 SHALL have port anime_state, output, 2, LED-matrix animation phase.
REQ-015 SHALL have port muted, output, 1, meaning the alarm has been acknowledged.

Function
REQ-016 SHALL encode state as IDLE=0, NORMAL=1, LOW=2, HIGH=3, OVER=4, FAULT=5; codes 6 and 7 are never driven.
REQ-017 SHALL, on the edge where number_valid=1, register level = tens*10 + ones as a 7-bit binary value.
REQ-018 SHALL set state on the next edge, giving a latency of 2 edges from the number_valid edge to the state change.
REQ-019 SHALL, on a sample with either digit >9, enter FAULT; any later valid-BCD sample SHALL reclassify normally.
REQ-020 SHALL stay in IDLE until the first sample after reset.
REQ-021 SHALL classify a sample from IDLE, FAULT or NORMAL as follows: level<LOW_TH gives LOW; LOW_TH..HIGH_TH-1 gives NORMAL; HIGH_TH..OVER_TH-1 gives HIGH; level>=OVER_TH gives OVER.
REQ-022 SHALL apply hysteresis on downgrades: OVER goes to HIGH only when level<OVER_TH-HYST, and HIGH goes to NORMAL only when level<HIGH_TH-HYST.
REQ-023 SHALL apply hysteresis on recovery: LOW goes to NORMAL only when level>=LOW_TH+HYST.
REQ-024 SHALL allow upgrades to higher severity with no hysteresis, including direct jumps such as LOW to OVER.
REQ-025 SHALL hold state between samples.
REQ-026 SHALL derive a 1 ms tick from a free-running counter of 0..TICK_DIV-1 that wraps.
REQ-027 SHALL also keep a ms counter of 0..999 that wraps, advancing on each tick and restarting at 0 on every state change.
REQ-028 SHALL set the beep pattern by state: LOW beeps during ms<100; HIGH beeps during ms<500; OVER beeps constantly; all other states are silent.
REQ-029 SHALL drive beep_en = pattern AND NOT muted, except in OVER, where beep_en = pattern regardless of muted.
REQ-030 SHALL treat btn0 as pressed once it has been stable high for DEB_MS consecutive ticks, producing a one-cycle press pulse.
REQ-031 SHALL set muted on a press pulse while in LOW, HIGH or OVER; a press in any other state SHALL be ignored.
REQ-032 SHALL clear muted on every state change.
REQ-033 SHALL, when a press and a state change occur on the same edge, let the clear win, so muted=0.
REQ-034 SHALL, in LOW/HIGH/OVER, advance anime_state by 1 (mod 4) every 250 ms (ms=0,250,500,750); otherwise anime_state=0.

Reset
REQ-035 SHALL, on rst=1 at a clk edge, set state=IDLE, beep_en=0, anime_state=0 and muted=0.
REQ-036 SHALL, on reset, also clear level, both counters and the debounce state.
REQ-037 SHALL discard a number_valid arriving on the same edge as rst.
REQ-038 SHALL treat reset mid-beep or mid-debounce as abandoning that activity immediately.

Structure
REQ-039 SHALL place the state-code constants and default thresholds in shared package water_pkg, which is also used by the display and led_matrix blocks.
REQ-040 SHALL implement the debounce logic as sub-module btn_debounce (ports clk, rst, tick, btn_raw, press).
REQ-041 SHALL keep the classifier, timers and pattern logic in level_alarm_ctrl.

Verification
REQ-042 SHALL test first-sample latency: after reset, send number=8'h50 with valid -> state goes 0 to 1 exactly 2 edges later, and beep_en stays 0.
REQ-043 SHALL test hysteresis: send 8'h85, then 8'h78, then 8'h76 -> state is HIGH, stays HIGH, then becomes NORMAL.
REQ-044 SHALL test the OVER beep and mute: send 8'h97 -> beep_en high continuously; then hold btn0 20 ms -> muted=1 but beep_en stays 1.
REQ-045 SHALL test the HIGH beep and mute: send 8'h85 -> beep_en high for 500 ms then low for 500 ms; a debounced press -> beep_en 0; then send 8'h96 -> muted=0.
REQ-046 SHALL test FAULT and debounce: send 8'h5A -> state=5; send 8'h10 -> state=2 (LOW); a btn0 glitch of 5 ms high -> no mute.
REQ-047 SHALL test reset mid-operation: assert rst during LOW at ms=50 -> next edge state=0, beep_en=0, anime_state=0.
